// File: rtl/code_prefetcher_if.sv
// Fabric-side bus of the command prefetcher.
//   master : prefetcher side (drives REQUEST, NUMBER_UNIT, ADDR, READ)
//   slave  : fabric side (drives EN, BUSY_SLAVE, RDATA, RVALID)
// Signals:
//   REQUEST     arbitration request
//   EN          arbitration grant
//   NUMBER_UNIT requesting unit id
//   ADDR        command address of the current burst
//   READ        one-cycle read strobe
//   BUSY_SLAVE  slave not ready, READ must be held off
//   RDATA       read beat
//   RVALID      RDATA valid
interface code_prefetcher_if #(
  parameter int SEG_W  = 8,
  parameter int BEAT_W = 8
);
  logic              REQUEST;
  logic              EN;
  logic [3:0]        NUMBER_UNIT;
  logic [SEG_W-1:0]  ADDR;
  logic              READ;
  logic              BUSY_SLAVE;
  logic [BEAT_W-1:0] RDATA;
  logic              RVALID;

  modport master (
    output REQUEST, NUMBER_UNIT, ADDR, READ,
    input  EN, BUSY_SLAVE, RDATA, RVALID
  );

  modport slave (
    input  REQUEST, NUMBER_UNIT, ADDR, READ,
    output EN, BUSY_SLAVE, RDATA, RVALID
  );
endinterface

// File: rtl/code_prefetcher.sv
// Command prefetch unit. Arbitrates for the shared fabric, reads one command
// per multi-beat burst, buffers up to DEPTH commands and presents the head
// command to the core. The core clock is sampled as data; each detected rising
// edge pops one command. FLUSH drops the buffer and restarts fetching at IP.
// Ports:
//   RESET      async active-low reset
//   CLK_B      block clock
//   CLK_C      core clock, sampled on CLK_B, rising edge = pop request
//   FLUSH      one-cycle pulse: discard buffer, refetch from IP
//   IP         restart command address, sampled on FLUSH
//   COMMAND    FIFO head command (registered)
//   CMD_VALID  FIFO non-empty
//   STORE_BUSY FIFO empty or flushing, core must stall
//   fab        fabric bus (master side)
module code_prefetcher #(
  parameter int         SEG_W   = 8,
  parameter int         BEAT_W  = 8,
  parameter int         BEATS   = 4,
  parameter int         DEPTH   = 4,
  parameter logic [3:0] UNIT_ID = 4'd0
) (
  input  logic                      RESET,
  input  logic                      CLK_B,
  input  logic                      CLK_C,
  input  logic                      FLUSH,
  input  logic [SEG_W-1:0]          IP,
  output logic [BEAT_W*BEATS-1:0]   COMMAND,
  output logic                      CMD_VALID,
  output logic                      STORE_BUSY,
  code_prefetcher_if.master         fab
);
  localparam int CMD_W = BEAT_W * BEATS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra pointer bit distinguishes full from empty.
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_ISSUE    = 3'd2,
    S_COLLECT  = 3'd3,
    S_FLUSHING = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               clk_c_s1_q, clk_c_s1_d;
  logic               clk_c_s2_q, clk_c_s2_d;
  logic               clk_c_edge_q, clk_c_edge_d;
  logic [CMD_W-1:0]   mem_q [DEPTH];
  logic [CMD_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [SEG_W-1:0]   fetch_ptr_q, fetch_ptr_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CMD_W-1:0]   asm_q, asm_d;
  logic [CMD_W-1:0]   command_q, command_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               store_busy_q, store_busy_d;
  logic               request_q, request_d;
  logic               read_q, read_d;
  logic [SEG_W-1:0]   addr_q, addr_d;

  logic               pop_edge_s;
  logic               pop_s;
  logic               collect_last_s;
  logic               wr_en_s;
  logic [PTR_W-1:0]   count_q_s;
  logic [PTR_W-1:0]   count_d_s;
  logic [CNT_W-1:0]   rem_s;

  assign COMMAND         = command_q;
  assign CMD_VALID       = cmd_valid_q;
  assign STORE_BUSY      = store_busy_q;
  assign fab.REQUEST     = request_q;
  assign fab.READ        = read_q;
  assign fab.ADDR        = addr_q;
  assign fab.NUMBER_UNIT = UNIT_ID;

  // Next-state logic: core-clock edge detect, FIFO, burst FSM and outputs.
  always_comb begin
    state_d        = state_q;
    clk_c_s1_d     = CLK_C;
    clk_c_s2_d     = clk_c_s1_q;
    clk_c_edge_d   = clk_c_s2_q;
    mem_d          = mem_q;
    fetch_ptr_d    = fetch_ptr_q;
    beat_d         = beat_q;
    flush_cnt_d    = flush_cnt_q;
    asm_d          = asm_q;
    read_d         = 1'b0;
    rem_s          = '0;

    pop_edge_s     = clk_c_s2_q & ~clk_c_edge_q;
    count_q_s      = wr_ptr_q - rd_ptr_q;
    // Pops on an empty FIFO are dropped; FLUSH cancels pop and write.
    pop_s          = pop_edge_s && (count_q_s != '0) && !FLUSH;
    collect_last_s = (state_q == S_COLLECT) && fab.RVALID && (beat_q == LAST_BEAT);
    wr_en_s        = collect_last_s && !FLUSH;

    if (FLUSH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_s);
    end
    count_d_s = wr_ptr_d - rd_ptr_d;

    case (state_q)
      S_IDLE: begin
        // Nothing is in flight here, so occupancy alone decides.
        if (count_q_s < DEPTH_P) state_d = S_REQ;
        else                     state_d = S_IDLE;
      end
      S_REQ: begin
        if (fab.EN) state_d = S_ISSUE;
        else        state_d = S_REQ;
      end
      S_ISSUE: begin
        if (!fab.BUSY_SLAVE) begin
          read_d  = 1'b1;
          state_d = S_COLLECT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_COLLECT: begin
        if (fab.RVALID) begin
          asm_d[int'(beat_q)*BEAT_W +: BEAT_W] = fab.RDATA;
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            fetch_ptr_d = fetch_ptr_q + SEG_W'(1);
            // Chain straight into the next burst while the grant holds and
            // the just-written command still leaves a slot free.
            if (fab.EN && (count_d_s < DEPTH_P)) state_d = S_ISSUE;
            else                                 state_d = S_IDLE;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      S_FLUSHING: begin
        if (fab.RVALID) begin
          if (flush_cnt_q <= CNT_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = S_IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q - CNT_W'(1);
          end
        end else begin
          flush_cnt_d = flush_cnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (FLUSH) begin
      beat_d      = '0;
      fetch_ptr_d = IP;
      read_d      = 1'b0;
      // Beats of an already issued burst are still coming; count them off.
      case (state_q)
        S_COLLECT:  rem_s = BEATS_C - beat_q - CNT_W'(fab.RVALID);
        S_FLUSHING: rem_s = flush_cnt_q - CNT_W'(fab.RVALID);
        default:    rem_s = '0;
      endcase
      if (rem_s != '0) begin
        state_d     = S_FLUSHING;
        flush_cnt_d = rem_s;
      end else begin
        state_d     = S_IDLE;
        flush_cnt_d = '0;
      end
    end else begin
      rem_s = '0;
    end

    if (wr_en_s) mem_d[wr_ptr_q[IDX_W-1:0]] = asm_d;
    else         mem_d = mem_q;

    cmd_valid_d  = (count_d_s != '0);
    command_d    = cmd_valid_d ? mem_d[rd_ptr_d[IDX_W-1:0]] : '0;
    store_busy_d = !cmd_valid_d || (state_d == S_FLUSHING);
    request_d    = (state_d != S_IDLE);
    addr_d       = (state_d == S_ISSUE) ? fetch_ptr_d : addr_q;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK_B or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      clk_c_s1_q   <= 1'b0;
      clk_c_s2_q   <= 1'b0;
      clk_c_edge_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      beat_q       <= '0;
      flush_cnt_q  <= '0;
      asm_q        <= '0;
      command_q    <= '0;
      cmd_valid_q  <= 1'b0;
      store_busy_q <= 1'b1;
      request_q    <= 1'b0;
      read_q       <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      clk_c_s1_q   <= clk_c_s1_d;
      clk_c_s2_q   <= clk_c_s2_d;
      clk_c_edge_q <= clk_c_edge_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      beat_q       <= beat_d;
      flush_cnt_q  <= flush_cnt_d;
      asm_q        <= asm_d;
      command_q    <= command_d;
      cmd_valid_q  <= cmd_valid_d;
      store_busy_q <= store_busy_d;
      request_q    <= request_d;
      read_q       <= read_d;
      addr_q       <= addr_d;
    end
  end
endmodule

// File: tb/tb_code_prefetcher.sv
module tb_code_prefetcher;
  localparam int SEG_W  = 8;
  localparam int BEAT_W = 8;
  localparam int BEATS  = 4;
  localparam int DEPTH  = 4;

  logic        clk_b = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_c = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  ip    = 8'h00;
  logic [31:0] command;
  logic        cmd_valid;
  logic        store_busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] junk;

  code_prefetcher_if #(.SEG_W(SEG_W), .BEAT_W(BEAT_W)) bus ();

  code_prefetcher #(
    .SEG_W(SEG_W), .BEAT_W(BEAT_W), .BEATS(BEATS), .DEPTH(DEPTH), .UNIT_ID(4'd5)
  ) dut (
    .RESET(rst_n),
    .CLK_B(clk_b),
    .CLK_C(clk_c),
    .FLUSH(flush),
    .IP(ip),
    .COMMAND(command),
    .CMD_VALID(cmd_valid),
    .STORE_BUSY(store_busy),
    .fab(bus.master)
  );

  always #5 clk_b = ~clk_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_b);
  endtask

  task automatic wait_read(input logic [7:0] exp_addr);
    int i;
    i = 0;
    while (bus.READ !== 1'b1 && i < 60) begin
      @(negedge clk_b);
      i++;
    end
    check("read_seen", 32'(bus.READ), 32'd1);
    check("addr", 32'(bus.ADDR), 32'(exp_addr));
  endtask

  task automatic beat(input logic [7:0] b);
    bus.RVALID = 1'b1;
    bus.RDATA  = b;
    @(negedge clk_b);
    bus.RVALID = 1'b0;
    bus.RDATA  = 8'h00;
  endtask

  task automatic send_cmd(input logic [31:0] c);
    for (int k = 0; k < BEATS; k++) beat(c[k*8 +: 8]);
    exp_q.push_back(c);
    check("cmd_valid", 32'(cmd_valid), 32'd1);
    check("head", command, exp_q[0]);
  endtask

  task automatic core_pop();
    check("head_pre", command, exp_q[0]);
    clk_c = 1'b1;
    tick(2);
    check("no_early_pop", command, exp_q[0]);
    tick(1);
    junk = exp_q.pop_front();
    check("head_post", command, exp_q[0]);
    tick(1);
    check("single_pop", command, exp_q[0]);
    clk_c = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.EN = 1'b0;
    bus.BUSY_SLAVE = 1'b0;
    bus.RDATA = 8'h00;
    bus.RVALID = 1'b0;
    tick(3);
    check("rst_command", command, 32'h0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_store_busy", 32'(store_busy), 32'd1);
    check("rst_request", 32'(bus.REQUEST), 32'd0);
    check("rst_read", 32'(bus.READ), 32'd0);
    check("rst_addr", 32'(bus.ADDR), 32'd0);
    check("number_unit", 32'(bus.NUMBER_UNIT), 32'd5);
    rst_n = 1'b1;
    bus.EN = 1'b1;

    // Fill the FIFO with four bursts.
    wait_read(8'h00); send_cmd(32'h04030201);
    wait_read(8'h01); send_cmd(32'h08070605);
    wait_read(8'h02); send_cmd(32'h0c0b0a09);
    wait_read(8'h03); send_cmd(32'h100f0e0d);
    check("full_req_drop", 32'(bus.REQUEST), 32'd0);
    check("full_store_busy", 32'(store_busy), 32'd0);
    tick(4);
    check("full_req_low", 32'(bus.REQUEST), 32'd0);
    check("full_read_low", 32'(bus.READ), 32'd0);

    // One pop from full, next burst held off by BUSY_SLAVE.
    bus.BUSY_SLAVE = 1'b1;
    core_pop();
    tick(3);
    check("refill_req", 32'(bus.REQUEST), 32'd1);
    check("refill_addr", 32'(bus.ADDR), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("read_busy", 32'(bus.READ), 32'd0);
      tick(1);
    end
    bus.BUSY_SLAVE = 1'b0;
    tick(1);
    check("read_after_busy", 32'(bus.READ), 32'd1);
    tick(1);
    check("read_once", 32'(bus.READ), 32'd0);
    send_cmd(32'h14131211);
    check("full_again_req", 32'(bus.REQUEST), 32'd0);

    // FLUSH after two beats of a burst.
    core_pop();
    wait_read(8'h05);
    beat(8'h61);
    beat(8'h62);
    ip = 8'h40;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_q.delete();
    check("flush_cmd_valid", 32'(cmd_valid), 32'd0);
    check("flush_store_busy", 32'(store_busy), 32'd1);
    check("flush_command", command, 32'h0);
    check("flush_req_held", 32'(bus.REQUEST), 32'd1);
    beat(8'hAA);
    beat(8'hBB);
    check("flush_done_req", 32'(bus.REQUEST), 32'd0);
    wait_read(8'h40);
    send_cmd(32'h24232221);

    // FLUSH in ISSUE cancels the read; fetch pointer wraps FF -> 00.
    ip = 8'hFF;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_q.delete();
    check("issue_flush_read", 32'(bus.READ), 32'd0);
    check("issue_flush_valid", 32'(cmd_valid), 32'd0);
    wait_read(8'hFF);
    send_cmd(32'h44434241);
    wait_read(8'h00);
    send_cmd(32'h48474645);

    // Pop request on an empty FIFO is ignored.
    ip = 8'h10;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_q.delete();
    wait_read(8'h10);
    clk_c = 1'b1;
    tick(5);
    check("empty_pop_valid", 32'(cmd_valid), 32'd0);
    check("empty_pop_busy", 32'(store_busy), 32'd1);
    check("empty_pop_cmd", command, 32'h0);
    clk_c = 1'b0;
    send_cmd(32'h54535251);

    // Reset in the middle of a burst.
    wait_read(8'h11);
    beat(8'h71);
    beat(8'h72);
    #2 rst_n = 1'b0;
    #1;
    check("arst_command", command, 32'h0);
    check("arst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("arst_store_busy", 32'(store_busy), 32'd1);
    check("arst_request", 32'(bus.REQUEST), 32'd0);
    check("arst_read", 32'(bus.READ), 32'd0);
    check("arst_addr", 32'(bus.ADDR), 32'd0);
    exp_q.delete();
    @(negedge clk_b);
    bus.EN = 1'b0;
    rst_n = 1'b1;
    beat(8'h73);
    beat(8'h74);
    check("late_beats_ignored", 32'(cmd_valid), 32'd0);
    check("post_rst_req", 32'(bus.REQUEST), 32'd1);
    bus.EN = 1'b1;
    wait_read(8'h00);
    send_cmd(32'h34333231);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/code_prefetcher.md
Name: code_prefetcher

Overview:
- Parametrised command prefetch unit between the core (CLK_C domain, sampled) and the shared data fabric; runs on CLK_B.
- Arbitrates for the fabric and reads commands as multi-beat bursts. Buffers up to DEPTH commands in a FIFO and presents the head command to the core.
- The core pops one command per detected CLK_C rising edge. A FLUSH (branch) discards the buffer and restarts fetching from a new IP.

Parameters:
- SEG_W, 8: width of the IP and the fabric address.
- BEAT_W, 8: fabric read data width per beat.
- BEATS, 4: beats per command. CMD_W = BEAT_W*BEATS.
- DEPTH, 4: FIFO depth in commands. Power of 2, >=2.
- UNIT_ID, 4'd0: value driven on NUMBER_UNIT.

Ports:
- RESET  in  1  async active-low reset
- CLK_B  in  1  block clock
- CLK_C  in  1  core clock, treated as data; sampled on CLK_B
- FLUSH  in  1  one-CLK_B pulse: discard buffer, refetch from IP
- IP  in  SEG_W  restart command address, sampled on FLUSH
- COMMAND  out  CMD_W  FIFO head command
- CMD_VALID  out  1  FIFO non-empty
- STORE_BUSY  out  1  high when FIFO empty or in FLUSHING state; core must stall
- REQUEST  out  1  fabric arbitration request
- EN  in  1  fabric grant
- NUMBER_UNIT  out  4  constant UNIT_ID
- ADDR  out  SEG_W  command address of current burst
- READ  out  1  one-cycle read strobe
- BUSY_SLAVE  in  1  fabric slave not ready
- RDATA  in  BEAT_W  read beat
- RVALID  in  1  RDATA valid

Behaviour:
- Reset values:
  - FIFO empty, rd/wr pointers 0, fetch pointer 0, state IDLE, CLK_C sync flops 0.
  - Outputs: COMMAND 0, CMD_VALID 0, STORE_BUSY 1, REQUEST 0, READ 0, ADDR 0.
- CLK_C sync: 2-flop synchroniser then an edge register. pop_edge = (sync2,edge_reg)==01, a one-cycle pulse 3 CLK_B cycles after the CLK_C rise at most.
- Pop: pop_edge && CMD_VALID advances rd pointer. pop_edge on empty FIFO is ignored (no underflow, pointers unchanged).
- COMMAND is registered from the FIFO head and valid the same cycle as CMD_VALID.
- FSM states:
  - IDLE: go to REQ if FIFO has a free slot counting in-flight commands (occupancy+inflight<DEPTH).
  - REQ: REQUEST=1 until EN=1, then go to ISSUE.
  - ISSUE: ADDR=fetch_ptr. READ=1 for exactly one cycle in which BUSY_SLAVE=0. While BUSY_SLAVE=1, hold READ=0 and stay. Then go to COLLECT.
  - COLLECT: assemble BEATS RVALID beats. Beat k goes to bits [k*BEAT_W +: BEAT_W] (first beat = LSBs).
    - On the last beat, write the FIFO and do fetch_ptr+1, wrapping from all-ones to 0.
    - Then go to ISSUE if EN still 1 and a slot is free; otherwise drop REQUEST and go to IDLE.
  - FLUSHING: REQUEST held. Discard remaining RVALID beats of the aborted burst, then go to IDLE.
- REQUEST stays high from REQ through the end of COLLECT. Losing EN mid-burst does not abort the burst.
- FLUSH:
  - Same cycle: FIFO cleared (pointers reset), beat counter cleared, fetch_ptr<=IP.
  - A concurrent pop or FIFO write is cancelled.
  - From IDLE/REQ: go to IDLE (REQUEST dropped).
  - From ISSUE before READ: go to IDLE.
  - From COLLECT with beats outstanding: go to FLUSHING with the remaining beat count.
- Full: no new burst is started when occupancy+inflight==DEPTH. Simultaneous pop and write keep occupancy constant.
- Reset mid-burst: all state returns to reset values immediately; late RVALID beats after reset are ignored in IDLE.

Test Plan:
- Reset, then bursts returning bytes 01..04, 05..08 (BEATS=4) -> REQUEST, EN=1 -> COMMAND=32'h04030201 with CMD_VALID=1; ADDR 0 then 1; FIFO fills to 4, then REQUEST drops.
- FIFO full, one CLK_C rise -> exactly one pop within 3 CLK_B cycles. COMMAND advances to 32'h08070605. A new burst is requested at ADDR=4.
- BUSY_SLAVE high 5 cycles in ISSUE -> READ stays low, then asserts for exactly 1 cycle after BUSY_SLAVE falls.
- FLUSH with IP=8'h40 after 2 of 4 beats -> FIFO empty, STORE_BUSY=1, last 2 beats discarded. Next burst ADDR=8'h40.
- fetch_ptr=8'hFF burst completes -> next ADDR=8'h00.
- CLK_C rising while FIFO empty -> pointers unchanged, CMD_VALID stays 0. RESET low mid-COLLECT -> all outputs at reset values asynchronously.
